// File: rtl/uart_dbg_pkg.sv
// Shared types and sizing helpers for the debug UART scheduler.
package uart_dbg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DATA_W = 8;

    // Clock cycles per UART bit period (integer divide).
    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Cycles one byte occupies the line: start + 8 data + stop + guard bits.
    function automatic int frame_cycles(input int clk_freq, input int baud_rate,
                                        input int guard_bits);
        return baud_div(clk_freq, baud_rate) * (10 + guard_bits);
    endfunction

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: the first requesting index after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      index
);

    int   idx;
    logic found;

    // Walk ptr+1, ptr+2, ... with wrap and take the first set request bit.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                index      = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ debug sources. Round-robin per message:
// a source whose byte is not flagged last keeps the UART locked until its last
// byte goes out or it stays silent for LOCK_TIMEOUT idle cycles. uart_tx has
// no done flag, so sends are paced by a local frame timer.
//
// Handshake: a requester raises req_valid with req_data/req_last stable and
// holds all three until it sees its one-cycle req_ready pulse; the byte is
// captured at the same edge that registers that pulse.
module uart_tx_scheduler
    import uart_dbg_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int NUM_REQ      = 4,
    parameter int GUARD_BITS   = 1,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          uart_din,
    output logic                       uart_send,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       lock_abort,
    output state_t                     state_dbg
);

    localparam int FRAME = frame_cycles(CLK_FREQ, BAUD_RATE, GUARD_BITS);
    localparam int IW    = $clog2(NUM_REQ);
    localparam int FW    = cnt_width(FRAME);
    localparam int TW    = cnt_width(LOCK_TIMEOUT);

    state_t              state;
    logic                locked;
    logic [IW-1:0]       rr_ptr;
    logic [FW-1:0]       frame_cnt;
    logic [TW-1:0]       lock_cnt;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [IW-1:0]       win_idx;
    logic [DATA_W-1:0]   win_data;
    logic                win_last;

    assign state_dbg = state;

    // While a message is in progress only its owner may be granted.
    always_comb begin
        elig = req_valid;
        if (locked) begin
            elig           = '0;
            elig[grant_id] = req_valid[grant_id];
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (win_onehot),
        .index (win_idx)
    );

    assign win_data = req_data[8*int'(win_idx) +: 8];
    assign win_last = req_last[win_idx];

    // Grant/send in IDLE, pace the frame in WAIT, expire stale locks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            locked     <= 1'b0;
            rr_ptr     <= IW'(NUM_REQ - 1);
            frame_cnt  <= '0;
            lock_cnt   <= '0;
            req_ready  <= '0;
            uart_din   <= '0;
            uart_send  <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= '0;
            lock_abort <= 1'b0;
        end else begin
            uart_send  <= 1'b0;
            req_ready  <= '0;
            lock_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        uart_din  <= win_data;
                        uart_send <= 1'b1;
                        req_ready <= win_onehot;
                        grant_id  <= win_idx;
                        rr_ptr    <= win_idx;
                        frame_cnt <= '0;
                        lock_cnt  <= '0;
                        locked    <= !win_last;
                        state     <= WAIT;
                        busy      <= 1'b1;
                    end else if (locked) begin
                        if (lock_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                            locked     <= 1'b0;
                            lock_abort <= 1'b1;
                            lock_cnt   <= '0;
                            busy       <= 1'b0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                            busy     <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (frame_cnt == FW'(FRAME - 1)) begin
                        state     <= IDLE;
                        frame_cnt <= '0;
                        busy      <= locked;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= locked;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a timeline reference model.
module tb_uart_tx_scheduler;
    import uart_dbg_pkg::*;

    localparam int NREQ    = 4;
    localparam int FRAME   = 110;
    localparam int SPACING = FRAME + 1;
    localparam int LOCK_TO = 50;
    localparam int QDEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        uart_din;
    logic              uart_send;
    logic              busy;
    logic [1:0]        grant_id;
    logic              lock_abort;
    state_t            state_dbg;

    uart_tx_scheduler #(
        .CLK_FREQ     (1000),
        .BAUD_RATE    (100),
        .NUM_REQ      (NREQ),
        .GUARD_BITS   (1),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_din   (uart_din),
        .uart_send  (uart_send),
        .busy       (busy),
        .grant_id   (grant_id),
        .lock_abort (lock_abort),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- requester message queues ----------------
    logic [7:0] q_data  [NREQ][QDEPTH];
    logic       q_last  [NREQ][QDEPTH];
    int         q_delay [NREQ][QDEPTH];
    int         q_head  [NREQ];
    int         q_tail  [NREQ];
    int         q_wait  [NREQ];
    logic       cur_v   [NREQ];

    task automatic clear_queues();
        for (int r = 0; r < NREQ; r++) begin
            q_head[r] = 0;
            q_tail[r] = 0;
            q_wait[r] = 0;
            cur_v[r]  = 1'b0;
        end
    endtask

    // Queue a byte for requester r; dly = idle cycles before it is offered.
    task automatic enqueue(input int r, input logic [7:0] d, input logic l, input int dly);
        if (q_tail[r] < QDEPTH) begin
            if (q_head[r] == q_tail[r]) q_wait[r] = dly;
            q_data[r][q_tail[r]]  = d;
            q_last[r][q_tail[r]]  = l;
            q_delay[r][q_tail[r]] = dly;
            q_tail[r]++;
        end
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int r = 0; r < NREQ; r++) if (q_head[r] < q_tail[r]) p = 1'b1;
        return p;
    endfunction

    // ---------------- reference model ----------------
    // The UART is free for a new grant from edge m_next_ok onward; a message
    // owner (m_owner >= 0) excludes everyone else until its last byte or until
    // it has been silent for LOCK_TO free edges.
    int         m_e, m_next_ok, m_owner, m_ptr, m_gid, m_stall, m_sends;
    logic       exp_send, exp_busy, exp_abort;
    logic [3:0] exp_ready;
    logic [7:0] exp_din;
    logic [9:0] exp_q[$];

    task automatic model_reset();
        m_e = 0; m_next_ok = 0; m_owner = -1; m_ptr = NREQ - 1;
        m_gid = 0; m_stall = 0;
        exp_send = 0; exp_busy = 0; exp_abort = 0; exp_ready = '0; exp_din = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l);
        int w;
        int c;
        exp_send  = 1'b0;
        exp_ready = '0;
        exp_abort = 1'b0;
        m_e++;
        w = -1;
        if (m_e >= m_next_ok) begin
            if (m_owner >= 0) begin
                if (v[m_owner]) w = m_owner;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (w < 0 && v[c]) w = c;
                end
            end
            if (w >= 0) begin
                exp_send     = 1'b1;
                exp_ready[w] = 1'b1;
                exp_din      = d[8*w +: 8];
                m_gid        = w;
                m_ptr        = w;
                m_next_ok    = m_e + SPACING;
                m_owner      = l[w] ? -1 : w;
                m_stall      = 0;
                m_sends++;
                exp_q.push_back({w[1:0], exp_din});
            end else if (m_owner >= 0) begin
                m_stall++;
                if (m_stall == LOCK_TO) begin
                    m_owner   = -1;
                    exp_abort = 1'b1;
                    m_stall   = 0;
                end
            end
        end
        exp_busy = (m_e < m_next_ok - 1) || (m_owner >= 0);
    endtask

    // ---------------- driver tasks ----------------
    // Retire accepted bytes, present the next ones, then predict the next edge.
    task automatic drive_and_predict();
        for (int r = 0; r < NREQ; r++) begin
            if (cur_v[r] && exp_ready[r]) begin
                q_head[r]++;
                cur_v[r] = 1'b0;
                if (q_head[r] < q_tail[r]) q_wait[r] = q_delay[r][q_head[r]];
            end
            if (!cur_v[r] && q_head[r] < q_tail[r]) begin
                if (q_wait[r] == 0) cur_v[r] = 1'b1;
                else q_wait[r]--;
            end
            req_valid[r] = cur_v[r];
            req_data[8*r +: 8] = cur_v[r] ? q_data[r][q_head[r]] : 8'($urandom);
            req_last[r] = cur_v[r] ? q_last[r][q_head[r]] : 1'($urandom);
        end
        model_step(req_valid, req_data, req_last);
    endtask

    task automatic tick();
        logic [9:0] got;
        @(posedge clk);
        #1;
        check("uart_send", uart_send, exp_send);
        check("req_ready", req_ready, exp_ready);
        check("busy", busy, exp_busy);
        check("grant_id", grant_id, m_gid);
        check("lock_abort", lock_abort, exp_abort);
        if (uart_send) begin
            if (exp_q.size() == 0) begin
                check("spurious_send", 1, 0);
            end else begin
                got = exp_q.pop_front();
                check("send_byte", {grant_id, uart_din}, got);
            end
        end
        drive_and_predict();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        clear_queues();
        @(posedge clk);
        #1;
        model_reset();
        check("rst_send", uart_send, 0);
        check("rst_din", uart_din, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_abort", lock_abort, 0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pending() || exp_busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("drain_timeout", 1, 0);
        repeat (3) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int mark;
        int n;
        int r;
        int len;
        int dly;
        m_sends = 0;
        clear_queues();
        do_reset();
        drive_and_predict();

        // single byte from requester 2
        enqueue(2, 8'hA5, 1'b1, 0);
        drain(400);

        // all four valid with single-byte messages, two rounds
        for (int k = 0; k < 2; k++)
            for (int q = 0; q < NREQ; q++) enqueue(q, 8'(8'h40 + 4*k + q), 1'b1, 0);
        drain(1500);

        // three-byte message from requester 1 against a waiting requester 0
        enqueue(1, 8'h10, 1'b0, 0);
        enqueue(1, 8'h11, 1'b0, 0);
        enqueue(1, 8'h12, 1'b1, 0);
        enqueue(0, 8'h77, 1'b1, 0);
        drain(1000);

        // requester 3 locks, goes silent, lock expires, requester 0 proceeds
        enqueue(3, 8'h33, 1'b0, 0);
        repeat (5) tick();
        enqueue(0, 8'h01, 1'b1, 0);
        enqueue(3, 8'h34, 1'b1, 250);
        drain(1500);

        // reset at frame counter 40, then two simultaneous requests on release
        mark = m_sends;
        enqueue(2, 8'hC3, 1'b1, 0);
        n = 0;
        while (m_sends == mark && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("wait_send_timeout", 1, 0);
        repeat (40) tick();
        do_reset();
        enqueue(3, 8'hD3, 1'b1, 0);
        enqueue(0, 8'hD0, 1'b1, 0);
        drive_and_predict();
        drain(600);

        // randomized messages with occasional long gaps inside messages
        for (int m = 0; m < 14; m++) begin
            r   = $urandom_range(0, NREQ - 1);
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
                dly = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 80) : $urandom_range(0, 3);
                enqueue(r, 8'($urandom), (b == len - 1), dly);
            end
        end
        drain(12000);

        check("exp_q_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one uart_tx byte transmitter between NUM_REQ debug sources, such as the SPI capture path and status/error reporters.
- Round-robin arbitration at message granularity: a granted source keeps the UART until its byte flagged last has gone out.
- Paces send pulses with an internal frame timer, because uart_tx exposes no busy/done.
- Sits between the logger's debug sources and the uart_tx din/send inputs.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: UART bit rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer divide).
- NUM_REQ, 4: number of requesters, range 2..8.
- GUARD_BITS, 1: extra idle bit periods added per frame; minimum 1.
- LOCK_TIMEOUT, 4096: idle cycles after which a held message lock is abandoned.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- req_valid, input, NUM_REQ: requester i has a byte pending.
- req_data, input, 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- req_last, input, NUM_REQ: the byte of requester i ends its message.
- req_ready, output, NUM_REQ: one-cycle acceptance pulse to requester i.
- uart_din, output, 8: byte to uart_tx.
- uart_send, output, 1: one-cycle send pulse to uart_tx.
- busy, output, 1: high while not in IDLE or while a lock is held.
- grant_id, output, $clog2(NUM_REQ): current or last granted requester.
- lock_abort, output, 1: one-cycle pulse when a lock times out.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, uart_din=0, uart_send=0, busy=0, grant_id=0, lock_abort=0.
- Reset internal state: state=IDLE, locked=0, rr pointer=NUM_REQ-1 so requester 0 has first priority, all counters 0.
- FRAME_CYCLES = BAUD_DIV*(10+GUARD_BITS).
- States are IDLE and WAIT.
- IDLE, unlocked:
  - Eligible set = req_valid.
  - Winner = first set bit searching from rr_ptr+1 upward with wrap.
  - On a winner, next cycle: uart_din=req_data[winner], uart_send=1, req_ready[winner]=1, grant_id=winner, rr_ptr=winner, frame counter=0, state=WAIT.
  - If req_last[winner]=0, set locked=1.
- IDLE, locked:
  - Only req_valid[grant_id] is eligible; all other requesters are ignored.
  - Sends exactly as in the unlocked case.
  - When the sent byte has req_last=1, clear locked.
- Latency: req_valid sampled high in IDLE gives uart_send and req_ready high on the next cycle.
- Requester handshake:
  - Requester holds data and last stable while valid is high until its ready pulse.
  - Valid may drop only after ready.
  - Data is sampled at the same edge the ready pulse is registered.
- WAIT:
  - Frame counter increments every cycle; uart_send and req_ready return to 0 after one cycle.
  - At counter==FRAME_CYCLES-1, return to IDLE.
  - Minimum spacing between uart_send pulses is FRAME_CYCLES+1 cycles.
- Lock timeout:
  - In IDLE with locked=1 and req_valid[grant_id]=0, a timeout counter increments.
  - The counter clears on any send.
  - At LOCK_TIMEOUT-1: clear locked, pulse lock_abort for 1 cycle, then arbitrate normally from the following cycle.
- Simultaneous requests: only one grant per arbitration; losers wait with valid held.
- rr_ptr advances only on a grant.
- A requester asserting valid in WAIT is not granted until IDLE.
- A single-byte message (last=1 on its first byte) never sets the lock.
- Reset mid-frame:
  - Returns immediately to the reset state.
  - No further uart_send.
  - uart_tx shares rst, so the partial frame is abandoned.

Decomposition:
- Package uart_dbg_pkg:
  - BAUD_DIV and FRAME_CYCLES localparam functions of CLK_FREQ, BAUD_RATE and GUARD_BITS.
  - State enum {IDLE, WAIT}.
  - Counter width helpers via $clog2.
- One sub-module, rr_arbiter: combinational round-robin priority select.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Parameter: NUM_REQ.
- The scheduler instantiates rr_arbiter with an eligibility mask applied while locked.

Test Plan:
Bench uses CLK_FREQ=1000, BAUD_RATE=100, so BAUD_DIV=10 and FRAME_CYCLES=110; NUM_REQ=4, LOCK_TIMEOUT=50.
- Requester 2 sends a single byte 0xA5 with last=1 -> next cycle uart_send=1, uart_din=0xA5, req_ready=4'b0100; busy drops 111 cycles after valid.
- All 4 valid continuously with last=1 -> grants 0,1,2,3,0 with send pulses exactly 111 cycles apart.
- Requester 1 sends a 3-byte message (0x10, 0x11, 0x12 with last on 0x12) while requester 0 is valid -> bytes 0x10, 0x11, 0x12 from requester 1 are sent back-to-back before any grant to requester 0.
- Requester 3 locks with last=0 and then drops valid -> lock_abort pulses 50 cycles after returning to IDLE; the next grant goes to the pending requester 0.
- Assert rst for 1 cycle at counter=40 of a frame -> all outputs 0 next cycle, state IDLE, locked=0; the next request is granted to requester 0.
- Two requesters valid in the same cycle as reset release -> the lowest index wins; the second is granted exactly 111 cycles later.
